// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of a single-port memory with a fixed LAT-cycle access.
// Data has priority, but fetch wins whenever the previous grant went to data. All outputs are registered except the stalls.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdData,
  output logic        i_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wrData,
  output logic [15:0] d_rdData,
  output logic        d_ready,
  output logic [15:0] m_addr,
  output logic        m_re,
  output logic        m_we,
  output logic [15:0] m_wrData,
  input  logic [15:0] m_rdData,
  output logic        i_stall,
  output logic        d_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       lastData;
  logic       winData;
  logic       isWrite;
  logic       dReq;
  logic       grantData;

  assign dReq      = d_rd | d_wr;
  assign grantData = dReq && !(lastData && i_req);

  assign i_stall = i_req & ~i_ready;
  assign d_stall = dReq & ~d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lastData <= 1'b0;
      winData  <= 1'b0;
      isWrite  <= 1'b0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 16'h0000;
      m_wrData <= 16'h0000;
      i_rdData <= 16'h0000;
      d_rdData <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          if (dReq || i_req) begin
            // A simultaneous read+write is served as a write only.
            winData  <= grantData;
            lastData <= grantData;
            isWrite  <= grantData && d_wr;
            m_addr   <= grantData ? d_addr : i_addr;
            if (grantData)
              m_wrData <= d_wrData;
            m_re     <= !(grantData && d_wr);
            m_we     <= grantData && d_wr;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            m_re <= 1'b0;
            m_we <= 1'b0;
            if (winData) begin
              d_ready <= 1'b1;
              if (!isWrite)
                d_rdData <= m_rdData;
            end else begin
              i_ready  <= 1'b1;
              i_rdData <= m_rdData;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=4): isolated accesses from a vector table,
// then hand-written sequences for simultaneous requests, fairness and reset mid-access.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdData;
  logic        i_ready;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wrData;
  logic [15:0] d_rdData;
  logic        d_ready;
  logic [15:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [15:0] m_wrData;
  logic [15:0] memData;
  logic        i_stall;
  logic        d_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdData(i_rdData), .i_ready(i_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wrData(d_wrData),
    .d_rdData(d_rdData), .d_ready(d_ready),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wrData(m_wrData),
    .m_rdData(memData), .i_stall(i_stall), .d_stall(d_stall)
  );

  typedef struct {
    logic        iReq;
    logic        dRd;
    logic        dWr;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] wrData;
    logic [15:0] mem;
    logic        expWe;
    logic [15:0] expAddr;
    logic        expD;
    logic [15:0] expIRd;
    logic [15:0] expDRd;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Serves one access with memory returning addr^5A5A; reports winner, address and idle gap.
  task automatic serveOne(output logic [15:0] addr, output logic isD, output int gap);
    int en;
    logic wasRead;
    gap  = 0;
    addr = 16'h0000;
    isD  = 1'b0;
    @(negedge clk);
    while (!(m_re || m_we) && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("grantTimeout", 32'(gap < 20), 32'd1);
    if (gap >= 20) return;
    addr    = m_addr;
    wasRead = m_re;
    memData = addr ^ 16'h5A5A;
    en = 0;
    while ((m_re || m_we) && en < 20) begin
      chk("exclusiveEn", 32'(m_re & m_we), 32'd0);
      chk("iStallBusy", 32'(i_stall), 32'(i_req));
      en++;
      @(negedge clk);
    end
    chk("enableLen", 32'(en), 32'(LAT));
    isD = d_ready;
    chk("onePulse", 32'(i_ready ^ d_ready), 32'd1);
    if (isD && wasRead)
      chk("dRdServe", 32'(d_rdData), 32'(addr ^ 16'h5A5A));
    else if (!isD)
      chk("iRdServe", 32'(i_rdData), 32'(addr ^ 16'h5A5A));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic        gotD;
    int          gap;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h1234, 16'h5555, 1'b1, 16'h0020, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 16'h9999, 16'hCAFE, 1'b0, 16'h0030, 1'b1, 16'hBEEF, 16'hCAFE};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 16'h0A0A, 16'h7777, 1'b1, 16'h0040, 1'b1, 16'hBEEF, 16'hCAFE};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 16'h1234, 1'b0, 16'h0F0F, 16'hCAFE};

    rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wrData = 16'h0; memData = 16'h0;
    repeat (3) @(negedge clk);
    chk("rstEnables", 32'({m_re, m_we}), 32'd0);
    chk("rstReady", 32'({i_ready, d_ready}), 32'd0);
    chk("rstAddr", 32'(m_addr), 32'd0);
    chk("rstWrData", 32'(m_wrData), 32'd0);
    chk("rstRdData", 32'({i_rdData, d_rdData}), 32'd0);
    rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("idleEnables", 32'({m_re, m_we, i_ready, d_ready}), 32'd0);
    end

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      i_req = vecs[v].iReq; d_rd = vecs[v].dRd; d_wr = vecs[v].dWr;
      i_addr = vecs[v].iAddr; d_addr = vecs[v].dAddr; d_wrData = vecs[v].wrData;
      memData = vecs[v].mem;
      for (int c = 0; c < LAT; c++) begin
        @(negedge clk);
        chk("vecRe", 32'(m_re), 32'(!vecs[v].expWe));
        chk("vecWe", 32'(m_we), 32'(vecs[v].expWe));
        chk("vecAddr", 32'(m_addr), 32'(vecs[v].expAddr));
        if (vecs[v].expWe)
          chk("vecWrData", 32'(m_wrData), 32'(vecs[v].wrData));
        chk("vecRdyLow", 32'({i_ready, d_ready}), 32'd0);
        chk("vecStall", 32'({i_stall, d_stall}), 32'({vecs[v].iReq, vecs[v].dRd | vecs[v].dWr}));
      end
      @(negedge clk);
      chk("vecIReady", 32'(i_ready), 32'(!vecs[v].expD));
      chk("vecDReady", 32'(d_ready), 32'(vecs[v].expD));
      chk("vecEnOff", 32'({m_re, m_we}), 32'd0);
      chk("vecIRd", 32'(i_rdData), 32'(vecs[v].expIRd));
      chk("vecDRd", 32'(d_rdData), 32'(vecs[v].expDRd));
      chk("vecStallRdy", 32'({i_stall, d_stall}), 32'd0);
      i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      @(negedge clk);
      chk("vecPulseEnd", 32'({i_ready, d_ready, m_re, m_we}), 32'd0);
    end

    // Simultaneous fetch and data read straight out of reset: data first.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
    serveOne(a, gotD, gap);
    chk("simulFirstD", 32'(gotD), 32'd1);
    chk("simulFirstAddr", 32'(a), 32'h0200);
    chk("simulIStall", 32'(i_stall), 32'd1);
    d_rd = 1'b0;
    serveOne(a, gotD, gap);
    chk("simulThenI", 32'(gotD), 32'd0);
    chk("simulIAddr", 32'(a), 32'h0100);
    chk("simulIGap", 32'(gap), 32'd1);
    chk("simulIStallRdy", 32'(i_stall), 32'd0);

    // Both held: grants alternate D, I, D, I with one idle cycle between accesses.
    d_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serveOne(a, gotD, gap);
      chk("fairWinner", 32'(gotD), 32'((k % 2) == 0));
      chk("fairAddr", 32'(a), ((k % 2) == 0) ? 32'h0200 : 32'h0100);
      chk("fairGap", 32'(gap), 32'd1);
    end
    i_req = 1'b0; d_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the second BUSY cycle of a read, request held through it.
    d_rd = 1'b1; d_addr = 16'h0300; memData = 16'hAAAA;
    @(negedge clk);
    chk("abortBusy1", 32'(m_re), 32'd1);
    @(negedge clk);
    chk("abortBusy2", 32'(m_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abortEnOff", 32'({m_re, m_we}), 32'd0);
    chk("abortNoRdy", 32'({i_ready, d_ready}), 32'd0);
    chk("abortAddr", 32'(m_addr), 32'd0);
    chk("abortDRd", 32'(d_rdData), 32'd0);
    rst = 1'b0;
    serveOne(a, gotD, gap);
    chk("regrantD", 32'(gotD), 32'd1);
    chk("regrantAddr", 32'(a), 32'h0300);
    d_rd = 1'b0;
    @(negedge clk);
    chk("finalIdle", 32'({m_re, m_we, i_ready, d_ready}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
